// File: rtl/vlc_tx_pkg.sv
// Shared constants and streamer state encoding for the VLC transmit path.
package vlc_tx_pkg;

    localparam int SYNC_LEN   = 480;
    localparam int FFT_POINT  = 64;
    localparam int CP_NUM     = 16;
    localparam int SYMBOL_NUM = 8;
    localparam int DATA_LEN   = (FFT_POINT + CP_NUM) * SYMBOL_NUM;
    localparam int FRAME_LEN  = SYNC_LEN + DATA_LEN;
    localparam int ADDR_W     = 11;
    localparam int DATA_W     = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_STREAM,
        S_DRAIN,
        S_DONE,
        S_GAP
    } streamer_state_t;

    function automatic logic is_busy(input streamer_state_t s);
        return (s == S_STREAM) || (s == S_DRAIN) || (s == S_DONE);
    endfunction

endpackage

// File: rtl/frame_streamer_if.sv
// Bundle between the frame streamer, the assembler read port and the DAC driver.
interface frame_streamer_if;
    import vlc_tx_pkg::*;

    logic              enable;
    logic              frame_ready;
    logic [ADDR_W-1:0] read_ptr;
    logic [DATA_W-1:0] frame_data;
    logic              tx_done;
    logic [DATA_W-1:0] dac_data;
    logic              dac_valid;
    logic              busy;
    logic [15:0]       frame_count;

    modport master (
        output enable, frame_ready, frame_data,
        input  read_ptr, tx_done, dac_data, dac_valid, busy, frame_count
    );

    modport slave (
        input  enable, frame_ready, frame_data,
        output read_ptr, tx_done, dac_data, dac_valid, busy, frame_count
    );

endinterface

// File: rtl/sample_strobe_gen.sv
// Divides clk down to the DAC sample rate; strobe is high whenever the counter sits at zero.
module sample_strobe_gen #(
    parameter int SAMPLE_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_strobe
);
    localparam int                 CNT_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

    logic [CNT_W-1:0] r_div_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_div_cnt <= '0;
        end else if (r_div_cnt == CNT_LAST) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + CNT_W'(1);
        end
    end

    assign o_strobe = (r_div_cnt == '0);

endmodule

// File: rtl/frame_streamer.sv
// Walks the assembled-frame buffer at the DAC sample rate and realigns the returned bytes
// into a paced sample stream, pulsing tx_done after the last sample to release the assembler.
module frame_streamer #(
    parameter int FRAME_LEN  = vlc_tx_pkg::FRAME_LEN,
    parameter int RD_LATENCY = 3,
    parameter int SAMPLE_DIV = 4,
    parameter int IFG        = 16
) (
    input  logic            clk,
    input  logic            rst,
    frame_streamer_if.slave bus
);
    import vlc_tx_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
    localparam logic [15:0]       GAP_LAST  = 16'(IFG - 1);

    streamer_state_t        r_state;
    streamer_state_t        w_next_state;
    logic                   w_strobe;
    logic                   w_issue;
    logic                   w_clear_div;
    logic [RD_LATENCY-1:0]  r_vpipe;
    logic [RD_LATENCY:0]    w_vshift;
    logic [15:0]            r_gap_cnt;
    logic [ADDR_W-1:0]      r_read_ptr;
    logic [DATA_W-1:0]      r_dac_data;
    logic                   r_dac_valid;
    logic [15:0]            r_frame_count;

    // Holding the divider clear outside STREAM makes the entry cycle the first strobe.
    assign w_clear_div = (r_state != S_STREAM);
    assign w_issue     = (r_state == S_STREAM) && w_strobe;
    assign w_vshift    = {r_vpipe, w_issue};

    sample_strobe_gen #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_strobe (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_clear_div),
        .o_strobe (w_strobe)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        bus.tx_done  = 1'b0;
        bus.busy     = is_busy(r_state);
        case (r_state)
            S_IDLE:   if (bus.enable) w_next_state = S_WAIT;
            S_WAIT: begin
                if (!bus.enable)          w_next_state = S_IDLE;
                else if (bus.frame_ready) w_next_state = S_STREAM;
            end
            S_STREAM: if (w_issue && (r_read_ptr == LAST_ADDR)) w_next_state = S_DRAIN;
            S_DRAIN:  if (r_vpipe == '0) w_next_state = S_DONE;
            S_DONE: begin
                bus.tx_done  = 1'b1;
                w_next_state = S_GAP;
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_LAST) w_next_state = bus.enable ? S_WAIT : S_IDLE;
            end
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vpipe       <= '0;
            r_dac_valid   <= 1'b0;
            r_dac_data    <= '0;
            r_read_ptr    <= '0;
            r_gap_cnt     <= '0;
            r_frame_count <= '0;
        end else begin
            r_vpipe     <= w_vshift[RD_LATENCY-1:0];
            r_dac_valid <= r_vpipe[RD_LATENCY-1];
            if (r_vpipe[RD_LATENCY-1]) begin
                r_dac_data <= bus.frame_data;
            end else if (w_next_state == S_DONE) begin
                r_dac_data <= '0;
            end
            // The final address holds through DRAIN and is cleared as DONE is entered.
            if ((r_state == S_WAIT) && (w_next_state == S_STREAM)) begin
                r_read_ptr <= '0;
            end else if (w_next_state == S_DONE) begin
                r_read_ptr <= '0;
            end else if (w_issue && (r_read_ptr != LAST_ADDR)) begin
                r_read_ptr <= r_read_ptr + ADDR_W'(1);
            end
            if (r_state == S_GAP) begin
                r_gap_cnt <= r_gap_cnt + 16'd1;
            end else begin
                r_gap_cnt <= '0;
            end
            if (r_state == S_DONE) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    assign bus.read_ptr    = r_read_ptr;
    assign bus.dac_data    = r_dac_data;
    assign bus.dac_valid   = r_dac_valid;
    assign bus.frame_count = r_frame_count;

endmodule
